// File: rtl/seg_scan_display.sv
// Six-digit multiplexed 7-segment driver for an HH.MM.SS BCD time bus, with a per-frame snapshot.
// Optional macro DP_BLINK_EN blinks the HH.MM.SS separator points at 1 Hz.
module seg_scan_display #(
  parameter int CLK_FREQ       = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] clock_time,
  input  logic        blank,
  output logic [7:0]  seg,
  output logic [5:0]  sel,
  output logic        frame_done
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0] SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0] SEL_MASK = SEL_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [CNT_W-1:0] scan_cnt_reg;
  logic [2:0]       idx_reg;
  logic [23:0]      snap_reg;
  logic             frame_done_reg;
  logic [7:0]       seg_reg;
  logic [5:0]       sel_reg;

  logic             tick;
  logic             frame_wrap;
  logic [5:0]       sel_raw;
  logic [3:0]       nibble;
  logic [6:0]       seg7_raw;
  logic             dp_level;
  logic             dp_raw;

  assign tick       = (scan_cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = tick && (idx_reg == 3'd5);

  // Scan timing and the frame snapshot; snap only moves on the 5->0 wrap so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg   <= '0;
      idx_reg        <= 3'd0;
      snap_reg       <= 24'h000000;
      frame_done_reg <= 1'b0;
    end else begin
      if (tick) begin
        scan_cnt_reg <= '0;
        idx_reg      <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + CNT_W'(1);
      end
      if (frame_wrap) begin
        snap_reg <= clock_time;
      end
      frame_done_reg <= frame_wrap;
    end
  end

  // One-hot digit select; also steers the nibble mux below.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sel
      assign sel_raw[gi] = (idx_reg == 3'(gi));
    end
  endgenerate

  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < 6; i++) begin
      if (sel_raw[i]) begin
        nibble = snap_reg[4*i +: 4];
      end
    end
  end

  always_comb begin
    seg7_raw = 7'h40;
    case (nibble)
      4'd0: seg7_raw = 7'h3F;
      4'd1: seg7_raw = 7'h06;
      4'd2: seg7_raw = 7'h5B;
      4'd3: seg7_raw = 7'h4F;
      4'd4: seg7_raw = 7'h66;
      4'd5: seg7_raw = 7'h6D;
      4'd6: seg7_raw = 7'h7D;
      4'd7: seg7_raw = 7'h07;
      4'd8: seg7_raw = 7'h7F;
      4'd9: seg7_raw = 7'h6F;
      default: seg7_raw = 7'h40;
    endcase
  end

`ifdef DP_BLINK_EN
  localparam int HALF_DIV = CLK_FREQ / 2;
  localparam int HALF_W   = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;

  logic [HALF_W-1:0] half_cnt_reg;
  logic              phase_reg;

  // Half-second timebase: phase flips every CLK_FREQ/2 clocks for a 1 Hz, 50% blink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_reg <= '0;
      phase_reg    <= 1'b1;
    end else if (half_cnt_reg == HALF_W'(HALF_DIV - 1)) begin
      half_cnt_reg <= '0;
      phase_reg    <= ~phase_reg;
    end else begin
      half_cnt_reg <= half_cnt_reg + HALF_W'(1);
    end
  end

  assign dp_level = phase_reg;
`else
  assign dp_level = 1'b1;
`endif

  assign dp_raw = (sel_raw[2] | sel_raw[4]) & dp_level;

  // Registered outputs; polarity is applied last so blank/reset mean "all off" in either sense.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= SEG_MASK;
      sel_reg <= SEL_MASK;
    end else if (blank) begin
      seg_reg <= SEG_MASK;
      sel_reg <= SEL_MASK;
    end else begin
      seg_reg <= {dp_raw, seg7_raw} ^ SEG_MASK;
      sel_reg <= sel_raw ^ SEL_MASK;
    end
  end

  assign seg        = seg_reg;
  assign sel        = sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: cycle-count reference model plus literal display checks.
// Honours DP_BLINK_EN in the model so either build can be checked.
module tb_seg_scan_display;

  localparam int CLK_FREQ = 1200;
  localparam int SCAN_HZ  = 100;
  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;   // 12
  localparam int FRAME    = 6 * SCAN_DIV;         // 72
  localparam int HALF     = CLK_FREQ / 2;         // 600

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] clock_time = 24'h000000;
  logic        blank = 1'b0;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  seg_scan_display #(
    .CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clock_time(clock_time), .blank(blank),
    .seg(seg), .sel(sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: everything is derived from the number of clock edges since reset.
  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int          e_m = 0;
  logic [23:0] snap_m = 24'h0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [5:0]  exp_sel = 6'h3F;
  logic        exp_fd = 1'b0;
  int          shown_idx = -1;
  int          idx_before;
  bit          dp_on;

  function automatic logic [7:0] model_seg(int i, logic [23:0] s, bit dp);
    logic [3:0] n;
    logic [6:0] c;
    n = s[4*i +: 4];
    c = (n < 4'd10) ? CODES[n] : 7'h40;
    return ~{dp && (i == 2 || i == 4), c};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      e_m = 0; snap_m = 24'h0; exp_seg = 8'hFF; exp_sel = 6'h3F; exp_fd = 1'b0; shown_idx = -1;
    end else begin
      idx_before = (e_m / SCAN_DIV) % 6;
`ifdef DP_BLINK_EN
      dp_on = (((e_m / HALF) % 2) == 0);
`else
      dp_on = 1'b1;
`endif
      if (blank) begin
        exp_seg = 8'hFF; exp_sel = 6'h3F; shown_idx = -1;
      end else begin
        exp_seg = model_seg(idx_before, snap_m, dp_on);
        exp_sel = ~(6'b1 << idx_before);
        shown_idx = idx_before;
      end
      e_m = e_m + 1;
      if (e_m % FRAME == 0) snap_m = clock_time;
      exp_fd = (e_m % FRAME == 0);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    checks = checks + 3;
    if (seg !== exp_seg) begin
      failures++; $display("FAIL model_seg t=%0t got=%h exp=%h", $time, seg, exp_seg);
    end
    if (sel !== exp_sel) begin
      failures++; $display("FAIL model_sel t=%0t got=%h exp=%h", $time, sel, exp_sel);
    end
    if (frame_done !== exp_fd) begin
      failures++; $display("FAIL model_fd t=%0t got=%b exp=%b", $time, frame_done, exp_fd);
    end
  end

  task automatic check_lit(string name, logic [7:0] s, logic [5:0] sl);
    checks++;
    if (seg !== s || sel !== sl) begin
      failures++;
      $display("FAIL %s got seg=%h sel=%h exp seg=%h sel=%h", name, seg, sel, s, sl);
    end else begin
      $display("ok   %s seg=%h sel=%h", name, seg, sel);
    end
  endtask

  task automatic wait_shown(int i);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (shown_idx == i) return;
    end
    checks++; failures++;
    $display("FAIL wait_idx%0d timeout got=%0d exp=%0d", i, shown_idx, i);
  endtask

  task automatic wait_fd();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) return;
    end
    checks++; failures++;
    $display("FAIL wait_frame_done timeout got=0 exp=1");
  endtask

  task automatic drive(logic [23:0] t, logic b);
    #1; clock_time = t; blank = b;
  endtask

  int period;

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 8'hFF || sel !== 6'h3F || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got seg=%h sel=%h fd=%b exp seg=ff sel=3f fd=0", seg, sel, frame_done);
    end else $display("ok   reset_state");
    #1 rst_n = 1'b1;

    // frame_done period
    wait_fd();
    period = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); period++;
      if (frame_done === 1'b1) break;
    end
    checks++;
    if (period != FRAME) begin
      failures++; $display("FAIL fd_period got=%0d exp=%0d", period, FRAME);
    end else $display("ok   fd_period %0d", period);

    // 12:34:56
    drive(24'h123456, 1'b0);
    wait_fd();
    wait_shown(0); check_lit("t2_idx0", 8'h82, 6'h3E);
    wait_shown(2); check_lit("t2_idx2", 8'h19, 6'h3B);
`ifndef DP_BLINK_EN
    checks++;
    if (seg[7] !== 1'b0) begin
      failures++; $display("FAIL dp_idx2 got=%b exp=0", seg[7]);
    end
`endif
    wait_shown(5); check_lit("t2_idx5", 8'hF9, 6'h1F);

    // mid-frame change must not tear the frame being scanned
    drive(24'h235959, 1'b0);
    wait_fd();
    wait_shown(0);
    wait_shown(3); check_lit("t3_idx3", 8'h92, 6'h37);
    drive(24'h000000, 1'b0);
    wait_shown(4); check_lit("t3_idx4", 8'h30, 6'h2F);
    wait_shown(5); check_lit("t3_idx5", 8'hA4, 6'h1F);
    wait_shown(0); check_lit("t3_next_idx0", 8'hC0, 6'h3E);
    wait_shown(2); check_lit("t3_next_idx2", 8'h40, 6'h3B);

    // non-BCD nibble shows a dash
    drive(24'h00000A, 1'b0);
    wait_fd();
    wait_shown(0); check_lit("t4_dash", 8'hBF, 6'h3E);

    // blanking
    drive(24'h123456, 1'b0);
    wait_fd();
    wait_shown(3);
    drive(24'h123456, 1'b1);
    @(negedge clk); check_lit("t5_blank", 8'hFF, 6'h3F);
    repeat (30) @(negedge clk);
    drive(24'h123456, 1'b0);
    wait_shown(3); check_lit("t5_resume_idx3", 8'hB0, 6'h37);

    // randomized run with one mid-frame reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) clock_time = $urandom;
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      if (c == 1537) rst_n = 1'b0;
      if (c == 1540) rst_n = 1'b1;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
